regfile_param: RTL
==================

# regfile_param

Parametrised multi-read-port register file with one write port, hardwired zero register, a write-address/data select stage, and a per-register pending-write scoreboard. It sits between decode and execute in the 16-bit datapath. It supplies registered operands to the ALU, store-data and branch-target paths, and accepts results from the ALU or MDR. It generalises the fixed 16×16, five-read-port file to arbitrary width, depth and port count, and adds reset clearing, optional bypass, and hazard flags.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 5, number of read ports

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  per-port read address; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, same packing
- rd_busy  out  NUM_RD  registered scoreboard bit of the address read on that port
- wr_en  in  1  commit write this cycle
- wr_dst_sel  in  1  1: write address = wr_addr_a; 0: write address = wr_addr_b
- wr_addr_a, wr_addr_b  in  ADDR_W  candidate write addresses (RT/BT field, SW/LW field)
- wr_mem_sel  in  1  1: write data = wr_data_mem; 0: write data = wr_data_alu
- wr_data_mem, wr_data_alu  in  DATA_W  candidate write data
- issue_en  in  1  mark the destination of a newly issued instruction as pending
- issue_addr  in  ADDR_W  register to mark pending
- busy_vec  out  DEPTH  current scoreboard state, bit r = register r pending

## Operation
- Write address and data are selected combinationally from the *_sel inputs. A write occurs at posedge when wr_en=1 and the selected address ≠ 0.
- Register 0 always reads 0. Writes to it are discarded. It never becomes busy. issue_en with issue_addr=0 is ignored.
- Read port i, on posedge with rd_en[i]=1:
  - rd_data[i] ← register[rd_addr[i]]
  - rd_busy[i] ← busy[rd_addr[i]]
- With rd_en[i]=0, port i holds its previous values.
- Scoreboard, per register r ≠ 0, at posedge:
  - issue_en && issue_addr==r → busy[r] ← 1. Issue takes priority: a new producer overrides the clear from a simultaneous write.
  - else write committed to r → busy[r] ← 0
  - else hold
- With wr_en=0, the select inputs are don't-care and no state changes.
- Multiple read ports may address the same register. All ports return identical data.

## Timing
- Read latency: 1 cycle (address at edge N, data valid after edge N).
- Write visible to a read sampled at the following edge. Same-edge read/write collision is governed by RF_BYPASS_EN.
- busy_vec updates at the same edge as the issue/write that changes it.
- Reset (async assert, any time, including mid-write): all registers = 0, rd_data = 0, rd_busy = 0, busy_vec = 0. Any in-flight write is lost. The first operation occurs at the first rising edge after deassertion.

## Configuration
- RF_BYPASS_EN defined: on a read/write collision to the same non-zero address at the same edge, rd_data returns the new write data and rd_busy returns the post-update busy bit (write-first).
- RF_BYPASS_EN undefined: a colliding read returns the old register contents and the pre-update busy bit (read-first). No forwarding mux is compiled in.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD constants
  - the ZERO_REG address constant
  - a typedef for the write-request bundle (en, dst_sel, mem_sel, addresses, data)
- Sub-module regfile_read_port: one instance per read port, generated NUM_RD times. It contains the address mux, the optional bypass compare/mux, and the output registers.
- The storage array and scoreboard live in regfile_param.

## Test plan
- Reset: assert rst mid-cycle with wr_en=1 to r5 → after deassert, read r5 → 0x0000, busy_vec=0.
- Write/read: wr_en, dst_sel=1, addr_a=3, mem_sel=0, alu=0xBEEF; next cycle read r3 on all 5 ports → every rd_data=0xBEEF one cycle later.
- Zero register: write 0x1234 to r0, issue_en addr 0 → reads of r0 return 0x0000, busy_vec[0]=0.
- Collision: write 0xA5A5 to r7 (old 0x0001) while port 2 reads r7 → rd_data[2]=0xA5A5 with RF_BYPASS_EN, 0x0001 without.
- Scoreboard: issue r9; next cycle read r9 → rd_busy=1; write r9 with mem_sel=1, mem=0x00FF → busy_vec[9]=0; simultaneous issue+write r9 → busy_vec[9] stays 1.
- Parameters: DATA_W=32, ADDR_W=5, NUM_RD=3; write 0xDEADBEEF to r31 → read r31 returns 0xDEADBEEF.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, write-request bundle and defaults for regfile_param
// Contents:
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD  default geometry of the register file
//   MAX_DATA_W / MAX_ADDR_W               widest configuration the request bundle can carry
//   ZERO_REG                              hardwired-zero register address
//   wr_req_t                              write-request bundle (enable, selects, candidate addresses/data)
package regfile_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NUM_RD = 5;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_ADDR_W = 8;
    localparam int ZERO_REG   = 0;
    // Fields are sized for the widest configuration; the top narrows them after selection.
    typedef struct packed {
        logic                  en;
        logic                  dst_sel;
        logic                  mem_sel;
        logic [MAX_ADDR_W-1:0] addr_a;
        logic [MAX_ADDR_W-1:0] addr_b;
        logic [MAX_DATA_W-1:0] data_mem;
        logic [MAX_DATA_W-1:0] data_alu;
    } wr_req_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port (address mux, optional write bypass, output flops)
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   en                           load the output registers this edge
//   addr                         register to read
//   regs                         flattened storage, register r at [r*DATA_W +: DATA_W]
//   busy                         scoreboard state before this edge
//   we, wr_addr, wr_data         committing write (present only with RF_BYPASS_EN)
//   busy_nxt                     scoreboard state after this edge (present only with RF_BYPASS_EN)
//   data, busy_bit               registered read data and scoreboard bit
// Build option: RF_BYPASS_EN selects write-first behaviour on a same-edge collision.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DEPTH*DATA_W-1:0] regs,
    input  logic [DEPTH-1:0]        busy,
`ifdef RF_BYPASS_EN
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DEPTH-1:0]        busy_nxt,
`endif
    output logic [DATA_W-1:0]       data,
    output logic                    busy_bit
);
    logic [DATA_W-1:0] sel_data;
    logic              sel_busy;
`ifdef RF_BYPASS_EN
    // we is already false for the zero register, so r0 never forwards.
    logic hit;
    assign hit = we && wr_addr == addr;
    always_comb begin
        sel_data = hit ? wr_data : regs[addr*DATA_W +: DATA_W];
        sel_busy = hit ? busy_nxt[addr] : busy[addr];
    end
`else
    always_comb begin
        sel_data = regs[addr*DATA_W +: DATA_W];
        sel_busy = busy[addr];
    end
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data     <= '0;
            busy_bit <= 1'b0;
        end else if (en) begin
            data     <= sel_data;
            busy_bit <= sel_busy;
        end
    end
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file, one write port, NUM_RD registered read ports, pending-write scoreboard
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rd_en, rd_addr                per-port read enable and packed addresses
//   rd_data, rd_busy              per-port registered data and scoreboard bit
//   wr_en, wr_dst_sel, wr_addr_a, wr_addr_b        write commit and destination select (1: a, 0: b)
//   wr_mem_sel, wr_data_mem, wr_data_alu            write data select (1: mem, 0: alu)
//   issue_en, issue_addr          mark a register pending
//   busy_vec                      scoreboard state
// Build option: RF_BYPASS_EN forwards a same-edge write to colliding reads.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic                     wr_dst_sel,
    input  logic [ADDR_W-1:0]        wr_addr_a,
    input  logic [ADDR_W-1:0]        wr_addr_b,
    input  logic                     wr_mem_sel,
    input  logic [DATA_W-1:0]        wr_data_mem,
    input  logic [DATA_W-1:0]        wr_data_alu,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [2**ADDR_W-1:0]     busy_vec
);
    localparam int DEPTH = 2 ** ADDR_W;
    wr_req_t                 req;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    we;
    logic                    issue;
    logic [DEPTH*DATA_W-1:0] regs;
    logic [DEPTH-1:0]        busy;
    logic [DEPTH-1:0]        busy_nxt;
    assign req = '{
        en:       wr_en,
        dst_sel:  wr_dst_sel,
        mem_sel:  wr_mem_sel,
        addr_a:   MAX_ADDR_W'(wr_addr_a),
        addr_b:   MAX_ADDR_W'(wr_addr_b),
        data_mem: MAX_DATA_W'(wr_data_mem),
        data_alu: MAX_DATA_W'(wr_data_alu)
    };
    assign wr_addr  = ADDR_W'(req.dst_sel ? req.addr_a : req.addr_b);
    assign wr_data  = DATA_W'(req.mem_sel ? req.data_mem : req.data_alu);
    assign we       = req.en && wr_addr != ADDR_W'(ZERO_REG);
    assign issue    = issue_en && issue_addr != ADDR_W'(ZERO_REG);
    assign busy_vec = busy;
    // Issue is applied last so a new producer wins over a same-edge clear.
    always_comb begin
        busy_nxt = busy;
        if (we) busy_nxt[wr_addr] = 1'b0;
        if (issue) busy_nxt[issue_addr] = 1'b1;
    end
    // Register 0 is never written, so its slice stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
            busy <= '0;
        end else begin
            busy <= busy_nxt;
            if (we) regs[wr_addr*DATA_W +: DATA_W] <= wr_data;
        end
    end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_read_port #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .DEPTH (DEPTH)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .en      (rd_en[i]),
            .addr    (rd_addr[i*ADDR_W +: ADDR_W]),
            .regs    (regs),
            .busy    (busy),
`ifdef RF_BYPASS_EN
            .we      (we),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .busy_nxt(busy_nxt),
`endif
            .data    (rd_data[i*DATA_W +: DATA_W]),
            .busy_bit(rd_busy[i])
        );
    end
endmodule
